// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) arbiter in front of a single-port synchronous-read RAM.
// Optional MEM_ARBITER_STATS_EN adds saturating stall / DMA-grant counters.
module mem_arbiter #(
  parameter int unsigned CPU_BURST_MAX = 4,
  parameter int unsigned DMA_BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_stall,
  output logic [15:0] cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [14:0] dma_addr,
  input  logic [15:0] dma_wdata,
  input  logic        dma_lock,
  output logic        dma_gnt,
  output logic [15:0] dma_rdata,
  output logic        dma_rvalid,
  output logic [14:0] ram_addr,
  output logic        ram_we,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] dma_cnt_total
`endif
);

  localparam int unsigned AW = 15;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CPU_MAX = CW'(CPU_BURST_MAX);
  localparam logic [CW-1:0] DMA_MAX = CW'(DMA_BURST_MAX);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU,
    ST_DMA
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cpu_cnt_q, cpu_cnt_d;
  logic [CW-1:0] dma_cnt_q, dma_cnt_d;
  logic [AW-1:0] addr_q;
  logic          cpu_rd_q, cpu_rd_d;
  logic          dma_rd_q, dma_rd_d;
  logic          cpu_gnt;
  logic          lock_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cpu_cnt_q <= '0;
      dma_cnt_q <= '0;
      addr_q    <= '0;
      cpu_rd_q  <= 1'b0;
      dma_rd_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_cnt_q <= cpu_cnt_d;
      dma_cnt_q <= dma_cnt_d;
      addr_q    <= ram_addr;
      cpu_rd_q  <= cpu_rd_d;
      dma_rd_q  <= dma_rd_d;
    end
  end

  // Grant selection, burst counters and read-owner tagging.
  always_comb begin
    state_d   = ST_IDLE;
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    cpu_cnt_d = cpu_cnt_q;
    dma_cnt_d = dma_cnt_q;
    lock_hold = (state_q == ST_DMA) && dma_lock && (dma_cnt_q < DMA_MAX);

    if (!rst) begin
      if (cpu_req && dma_req) begin
        if ((cpu_cnt_q == CPU_MAX) || lock_hold) dma_gnt = 1'b1;
        else                                     cpu_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req;
      end
    end

    if (cpu_gnt)      state_d = ST_CPU;
    else if (dma_gnt) state_d = ST_DMA;

    if (dma_gnt || !dma_req)                  cpu_cnt_d = '0;
    else if (cpu_gnt && (cpu_cnt_q < CPU_MAX)) cpu_cnt_d = cpu_cnt_q + CW'(1);

    if (!dma_gnt)                  dma_cnt_d = '0;
    else if (dma_cnt_q < DMA_MAX)  dma_cnt_d = dma_cnt_q + CW'(1);

    cpu_rd_d = cpu_gnt & ~cpu_we;
    dma_rd_d = dma_gnt & ~dma_we;
  end

  // RAM port follows the winner; address parks on its last value when idle.
  assign ram_addr  = rst     ? '0 :
                     cpu_gnt ? cpu_addr :
                     dma_gnt ? dma_addr : addr_q;
  assign ram_we    = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
  assign ram_wdata = dma_gnt ? dma_wdata : cpu_wdata;

  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign cpu_rdata  = ram_rdata;
  assign dma_rdata  = ram_rdata;
  // A reset arriving while read data is due squashes the valid.
  assign cpu_rvalid = cpu_rd_q & ~rst;
  assign dma_rvalid = dma_rd_q & ~rst;

`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] dma_tot_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      dma_tot_q   <= '0;
    end else begin
      if (cpu_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (dma_gnt && (dma_tot_q != 16'hFFFF))     dma_tot_q   <= dma_tot_q + 16'd1;
    end
  end

  assign stall_cnt     = stall_cnt_q;
  assign dma_cnt_total = dma_tot_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// run-length / pending-read reference model and a shadow copy of RAM contents.
module tb_mem_arbiter;

  localparam int unsigned CMAX = 4;
  localparam int unsigned DMAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [14:0] cpu_addr, dma_addr;
  logic [15:0] cpu_wdata, dma_wdata;
  logic        cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, ram_we;
  logic [15:0] cpu_rdata, dma_rdata, ram_wdata, ram_rdata;
  logic [14:0] ram_addr;
`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] stall_cnt, dma_cnt_total;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.CPU_BURST_MAX(CMAX), .DMA_BURST_MAX(DMAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef MEM_ARBITER_STATS_EN
    , .stall_cnt(stall_cnt), .dma_cnt_total(dma_cnt_total)
`endif
  );

  // Power-on RAM contents, with the values the directed tests rely on.
  function automatic logic [15:0] dflt(input logic [14:0] a);
    case (a)
      15'h0010: return 16'h1234;
      15'h0001: return 16'hBEEF;
      15'h4000: return 16'hCAFE;
      default:  return (16'(a) * 16'd7) ^ 16'h5A5A;
    endcase
  endfunction

  logic [15:0] mem [0:32767];
  bit          mem_wr [0:32767];

  always @(posedge clk) begin
    ram_rdata <= mem_wr[ram_addr] ? mem[ram_addr] : dflt(ram_addr);
    if (ram_we) begin
      mem[ram_addr]    <= ram_wdata;
      mem_wr[ram_addr] <= 1'b1;
    end
  end

  // Reference model state
  int          m_last = 0;        // 0 none, 1 cpu, 2 dma granted last cycle
  int          m_cpu_run = 0;     // CPU grants in a row while DMA waited
  int          m_dma_run = 0;     // DMA grants in a row
  int          m_pend = 0;        // owner of the read whose data is due next cycle
  logic [15:0] m_pend_data = '0;
  logic [14:0] m_addr_last = '0;
  int          m_stalls = 0;
  int          m_dma_total = 0;
  logic [15:0] ref_mem [0:32767];
  bit          ref_wr  [0:32767];

  logic        e_cpu_g, e_dma_g, e_stall, e_we, e_cpu_rv, e_dma_rv;
  logic [14:0] e_addr;
  logic [15:0] e_rdata, e_wdata;

  task automatic cycle(input logic r, input logic cr, input logic cw, input logic [14:0] ca,
                       input logic dr, input logic dw, input logic [14:0] da, input logic lk);
    logic        held;
    logic [15:0] cd, dd;
    cd = 16'($urandom);
    dd = 16'($urandom);
    @(posedge clk);
    #1;
    rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd; dma_lock = lk;
    @(negedge clk);
    e_cpu_g = 1'b0;
    e_dma_g = 1'b0;
    if (!r) begin
      if (cr && dr) begin
        held = (m_last == 2) && lk && (m_dma_run < int'(DMAX));
        if ((m_cpu_run >= int'(CMAX)) || held) e_dma_g = 1'b1;
        else                                   e_cpu_g = 1'b1;
      end else begin
        e_cpu_g = cr;
        e_dma_g = dr;
      end
    end
    e_stall  = cr && !e_cpu_g;
    e_we     = (e_cpu_g && cw) || (e_dma_g && dw);
    e_wdata  = e_cpu_g ? cd : dd;
    e_addr   = r ? 15'h0 : e_cpu_g ? ca : e_dma_g ? da : m_addr_last;
    e_cpu_rv = !r && (m_pend == 1);
    e_dma_rv = !r && (m_pend == 2);
    e_rdata  = m_pend_data;
    if (r) begin
      m_last = 0; m_cpu_run = 0; m_dma_run = 0; m_pend = 0;
      m_addr_last = '0; m_stalls = 0; m_dma_total = 0;
    end else begin
      if (e_dma_g || !dr) m_cpu_run = 0;
      else if (e_cpu_g)   m_cpu_run = (m_cpu_run + 1 > int'(CMAX)) ? int'(CMAX) : m_cpu_run + 1;
      m_dma_run = !e_dma_g ? 0 : (m_dma_run + 1 > int'(DMAX)) ? int'(DMAX) : m_dma_run + 1;
      m_last = e_cpu_g ? 1 : e_dma_g ? 2 : 0;
      m_pend = 0;
      if ((e_cpu_g || e_dma_g) && !e_we) begin
        m_pend      = e_cpu_g ? 1 : 2;
        m_pend_data = ref_wr[e_addr] ? ref_mem[e_addr] : dflt(e_addr);
      end
      if (e_we) begin
        ref_mem[e_addr] = e_wdata;
        ref_wr[e_addr]  = 1'b1;
      end
      m_addr_last = e_addr;
      if (e_stall && m_stalls < 65535)     m_stalls++;
      if (e_dma_g && m_dma_total < 65535)  m_dma_total++;
    end
  endtask

  task automatic idle(input logic r);
    cycle(r, 1'b0, 1'b0, 15'h0, 1'b0, 1'b0, 15'h0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'($urandom), 1'($urandom), 15'($urandom), 1'($urandom), 1'($urandom),
            15'($urandom), 1'($urandom));
      checks++; if (dma_gnt !== 1'b0)     begin errors++; $display("FAIL reset_dma_gnt got=%b exp=0", dma_gnt); end
      checks++; if (ram_we !== 1'b0)      begin errors++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
      checks++; if (ram_addr !== 15'h0)   begin errors++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
      checks++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0)
        begin errors++; $display("FAIL reset_rvalid got=%b%b exp=00", cpu_rvalid, dma_rvalid); end
    end
    cycle(1'b0, 1'b1, 1'b0, 15'h0055, 1'b0, 1'b0, 15'h0, 1'b0);
    checks++; if (cpu_stall !== 1'b0)   begin errors++; $display("FAIL first_grant_stall got=%b exp=0", cpu_stall); end
    checks++; if (ram_addr !== 15'h0055) begin errors++; $display("FAIL first_grant_addr got=%h exp=0055", ram_addr); end
    idle(1'b0);
    checks++; if (cpu_rvalid !== e_cpu_rv || cpu_rdata !== e_rdata)
      begin errors++; $display("FAIL first_grant_rdata got=%b/%h exp=%b/%h", cpu_rvalid, cpu_rdata, e_cpu_rv, e_rdata); end
  endtask

  task automatic test_cpu_read();
    idle(1'b0);
    cycle(1'b0, 1'b1, 1'b0, 15'h0010, 1'b0, 1'b0, 15'h0, 1'b0);
    checks++; if (cpu_stall !== 1'b0)    begin errors++; $display("FAIL cpu_read_stall got=%b exp=0", cpu_stall); end
    checks++; if (ram_addr !== 15'h0010 || ram_we !== 1'b0)
      begin errors++; $display("FAIL cpu_read_port got=%h/%b exp=0010/0", ram_addr, ram_we); end
    idle(1'b0);
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h1234)
      begin errors++; $display("FAIL cpu_read_data got=%b/%h exp=1/1234", cpu_rvalid, cpu_rdata); end
    checks++; if (dma_rvalid !== 1'b0)   begin errors++; $display("FAIL cpu_read_dma_rv got=%b exp=0", dma_rvalid); end
    idle(1'b0);
    checks++; if (cpu_rvalid !== 1'b0)   begin errors++; $display("FAIL cpu_read_one_cycle got=%b exp=0", cpu_rvalid); end
    checks++; if (ram_addr !== 15'h0010) begin errors++; $display("FAIL idle_addr_hold got=%h exp=0010", ram_addr); end
  endtask

  task automatic test_burst();
    idle(1'b0);
    for (int k = 0; k < 15; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 15'($urandom), 1'b1, 1'b0, 15'($urandom), 1'b0);
      checks++; if (dma_gnt !== (k % 5 == 4))
        begin errors++; $display("FAIL burst_gnt k=%0d got=%b exp=%b", k, dma_gnt, (k % 5 == 4)); end
      checks++; if (cpu_stall !== (k % 5 == 4))
        begin errors++; $display("FAIL burst_stall k=%0d got=%b exp=%b", k, cpu_stall, (k % 5 == 4)); end
      checks++; if (cpu_rvalid !== e_cpu_rv || dma_rvalid !== e_dma_rv ||
                    ((e_cpu_rv || e_dma_rv) && cpu_rdata !== e_rdata))
        begin errors++; $display("FAIL burst_rd k=%0d got=%b%b/%h exp=%b%b/%h", k, cpu_rvalid,
                                 dma_rvalid, cpu_rdata, e_cpu_rv, e_dma_rv, e_rdata); end
    end
  endtask

  task automatic test_dma_lock();
    idle(1'b0);
    for (int k = 0; k < 11; k++) begin
      cycle(1'b0, (k != 0), 1'b0, 15'h0100, 1'b1, 1'b0, 15'($urandom), 1'b1);
      checks++; if (dma_gnt !== (k < 8))
        begin errors++; $display("FAIL lock_gnt k=%0d got=%b exp=%b", k, dma_gnt, (k < 8)); end
      checks++; if (cpu_stall !== (k >= 1 && k < 8))
        begin errors++; $display("FAIL lock_stall k=%0d got=%b exp=%b", k, cpu_stall, (k >= 1 && k < 8)); end
    end
  endtask

  task automatic test_back_to_back();
    idle(1'b0);
    cycle(1'b0, 1'b1, 1'b0, 15'h0001, 1'b0, 1'b0, 15'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 15'h0, 1'b1, 1'b0, 15'h4000, 1'b0);
    checks++; if (dma_gnt !== 1'b1 || ram_addr !== 15'h4000)
      begin errors++; $display("FAIL b2b_dma_gnt got=%b/%h exp=1/4000", dma_gnt, ram_addr); end
    checks++; if (cpu_rvalid !== 1'b1 || dma_rvalid !== 1'b0 || cpu_rdata !== 16'hBEEF)
      begin errors++; $display("FAIL b2b_cpu_data got=%b%b/%h exp=10/beef", cpu_rvalid, dma_rvalid, cpu_rdata); end
    idle(1'b0);
    checks++; if (dma_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || dma_rdata !== 16'hCAFE)
      begin errors++; $display("FAIL b2b_dma_data got=%b%b/%h exp=01/cafe", cpu_rvalid, dma_rvalid, dma_rdata); end
  endtask

  task automatic test_reset_inflight();
    idle(1'b0);
    cycle(1'b0, 1'b1, 1'b0, 15'h0020, 1'b1, 1'b0, 15'h0030, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 15'h0021, 1'b1, 1'b0, 15'h0031, 1'b0);
    idle(1'b1);
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL inflight_rst_rv got=%b exp=0", cpu_rvalid); end
    idle(1'b0);
    checks++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0)
      begin errors++; $display("FAIL inflight_after_rv got=%b%b exp=00", cpu_rvalid, dma_rvalid); end
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 15'($urandom), 1'b1, 1'b0, 15'($urandom), 1'b0);
      checks++; if (dma_gnt !== (k == 4))
        begin errors++; $display("FAIL inflight_cnt_clear k=%0d got=%b exp=%b", k, dma_gnt, (k == 4)); end
    end
  endtask

`ifdef MEM_ARBITER_STATS_EN
  task automatic test_stats();
    idle(1'b1);
    cycle(1'b0, 1'b0, 1'b0, 15'h0, 1'b1, 1'b0, 15'h0200, 1'b1);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0, 15'h0201, 1'b1, 1'b0, 15'h0202, 1'b1);
    idle(1'b0);
    checks++; if (stall_cnt !== 16'd5)     begin errors++; $display("FAIL stats_stall got=%0d exp=5", stall_cnt); end
    checks++; if (dma_cnt_total !== 16'd6) begin errors++; $display("FAIL stats_dma got=%0d exp=6", dma_cnt_total); end
  endtask
`endif

  task automatic test_random();
    logic r, cr, dr;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      cr = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 2) != 0);
      cycle(r, cr, 1'($urandom), 15'(15'h0100 + 15'($urandom_range(0, 63))),
            dr, 1'($urandom), 15'(15'h0100 + 15'($urandom_range(0, 63))), ($urandom_range(0, 3) != 0));
      checks++; if (dma_gnt !== e_dma_g || cpu_stall !== e_stall)
        begin errors++; $display("FAIL rand_gnt i=%0d got=%b/%b exp=%b/%b", i, dma_gnt, cpu_stall, e_dma_g, e_stall); end
      checks++; if (ram_we !== e_we || ram_addr !== e_addr || (e_we && ram_wdata !== e_wdata))
        begin errors++; $display("FAIL rand_port i=%0d got=%b/%h/%h exp=%b/%h/%h", i, ram_we, ram_addr,
                                 ram_wdata, e_we, e_addr, e_wdata); end
      checks++; if (cpu_rvalid !== e_cpu_rv || dma_rvalid !== e_dma_rv)
        begin errors++; $display("FAIL rand_rvalid i=%0d got=%b%b exp=%b%b", i, cpu_rvalid, dma_rvalid, e_cpu_rv, e_dma_rv); end
      if (e_cpu_rv || e_dma_rv) begin
        checks++; if (cpu_rdata !== e_rdata || dma_rdata !== e_rdata)
          begin errors++; $display("FAIL rand_rdata i=%0d got=%h/%h exp=%h", i, cpu_rdata, dma_rdata, e_rdata); end
      end
`ifdef MEM_ARBITER_STATS_EN
      checks++; if (stall_cnt !== 16'(m_stalls) || dma_cnt_total !== 16'(m_dma_total))
        begin errors++; $display("FAIL rand_stats i=%0d got=%0d/%0d exp=%0d/%0d", i, stall_cnt,
                                 dma_cnt_total, m_stalls, m_dma_total); end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; dma_lock = 1'b0;
    test_reset();
    test_cpu_read();
    test_burst();
    test_dma_lock();
    test_back_to_back();
    test_reset_inflight();
`ifdef MEM_ARBITER_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter CPU_BURST_MAX, default 4: consecutive CPU grants allowed while DMA waits (range 1-15).
REQ-002 The block SHALL have parameter DMA_BURST_MAX, default 8: consecutive DMA grants allowed while dma_lock is held (range 1-15).
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous reset, active-high.
REQ-005 Port cpu_req, input, 1: CPU data-memory access this cycle.
REQ-006 Port cpu_we, input, 1: CPU write enable (writeM).
REQ-007 Port cpu_addr, input, 15: CPU address (addressM).
REQ-008 Port cpu_wdata, input, 16: CPU write data (outM).
REQ-009 Port cpu_stall, output, 1: CPU held; PC and registers freeze.
REQ-010 Port cpu_rdata, output, 16: read data to the CPU (inM).
REQ-011 Port cpu_rvalid, output, 1: cpu_rdata is valid this cycle.
REQ-012 Ports dma_req (input, 1), dma_we (input, 1), dma_addr (input, 15), dma_wdata (input, 16): secondary requester (screen/DMA).
REQ-013 Port dma_lock, input, 1: the DMA requests a burst hold.
REQ-014 Ports dma_gnt (output, 1), dma_rdata (output, 16), dma_rvalid (output, 1): DMA grant, read data, and read valid.
REQ-015 Ports ram_addr (output, 15), ram_we (output, 1), ram_wdata (output, 16), ram_rdata (input, 16): single-port RAM with 1-cycle synchronous read.

Function
REQ-016 The FSM SHALL have three states. IDLE: no grant. CPU: cpu_gnt is high. DMA: dma_gnt is high. The next state is chosen every cycle from the requests.
REQ-017 Each cycle SHALL grant at most one requester, and the grant is combinational from the current requests and registered counters.
REQ-018 If only one requester is active, that requester SHALL be granted.
REQ-019 If both requesters are active, the CPU SHALL win unless cpu_cnt == CPU_BURST_MAX, or the FSM is in DMA with dma_lock high and dma_cnt < DMA_BURST_MAX.
REQ-020 cpu_cnt SHALL increment on a CPU grant while dma_req is high, clear on any DMA grant or when dma_req is low, and never exceed CPU_BURST_MAX.
REQ-021 dma_cnt SHALL increment on each DMA grant, clear on a CPU grant or IDLE, and saturate at DMA_BURST_MAX. At that value the lock is ignored and normal priority applies.
REQ-022 ram_addr, ram_we and ram_wdata SHALL carry the granted requester's signals. With no grant, ram_we is 0 and ram_addr holds its last value.
REQ-023 cpu_stall SHALL equal cpu_req & ~cpu_gnt, combinationally.
REQ-024 A granted read (we = 0) SHALL produce a registered owner tag; the next cycle asserts the owner's rvalid for exactly 1 cycle with rdata = ram_rdata.
REQ-025 A granted write SHALL complete in the grant cycle and SHALL NOT assert rvalid.
REQ-026 cpu_rdata and dma_rdata SHALL both be driven from ram_rdata; only the rvalid signals discriminate.
REQ-027 Back-to-back reads by alternating owners SHALL return each datum to the correct owner with no bubble.

Reset
REQ-028 While rst is high: state IDLE, cpu_cnt = 0, dma_cnt = 0, owner tag cleared, cpu_rvalid = 0, dma_rvalid = 0, ram_we = 0, ram_addr = 0.
REQ-029 rst asserted with a read in flight SHALL drop that read: no rvalid in the cycle after reset.
REQ-030 The first grant after reset SHALL occur in the first cycle with rst low.

Configuration
REQ-031 Macro MEM_ARBITER_STATS_EN SHALL be the single configuration feature.
REQ-032 With MEM_ARBITER_STATS_EN defined, the block SHALL add output ports stall_cnt (16) and dma_cnt_total (16). These are saturating counts of cpu_stall cycles and DMA grants, cleared by rst.
REQ-033 Without MEM_ARBITER_STATS_EN, those ports and counters SHALL be absent, and all other behaviour is identical.

Verification
REQ-034 Bench: CPU read addr 0x0010 (RAM = 0x1234), no DMA -> cpu_stall = 0, next cycle cpu_rvalid = 1, cpu_rdata = 0x1234.
REQ-035 Bench: cpu_req and dma_req held high, CPU_BURST_MAX = 4 -> grants repeat C,C,C,C,D, and cpu_stall is high exactly in each D cycle.
REQ-036 Bench: DMA granted with dma_lock high, CPU requesting, DMA_BURST_MAX = 8 -> 8 consecutive DMA grants, then the CPU is granted.
REQ-037 Bench: CPU read 0x0001 then DMA read 0x4000 in consecutive cycles -> cpu_rvalid in cycle 2 and dma_rvalid in cycle 3, each with the correct data.
REQ-038 Bench: rst pulsed in the cycle after a CPU read grant -> cpu_rvalid stays 0, and all counters read 0.
REQ-039 Bench: with MEM_ARBITER_STATS_EN defined, 5 stall cycles are injected -> stall_cnt = 5; with the macro undefined, the design elaborates without the port.
